// File: rtl/adder_checker.sv
// Response checker for WIDTH-bit adders: compares {cout,sum} against a golden a+b+cin
// over a bounded run. Define ADDER_CHECKER_CAPTURE_EN to latch the first failing vector.
module adder_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH:0]   fail_got,
  output logic [WIDTH:0]   fail_exp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic               cmp_vld_q;
  logic [WIDTH-1:0]   cmp_a_q, cmp_b_q;
  logic               cmp_cin_q;
  logic [WIDTH:0]     cmp_got_q;

  logic               accept;
  logic [WIDTH:0]     exp_w;
  logic               mism;

  assign in_ready  = (state_q == RUN) && (vec_q != target_q);
  assign accept    = in_valid && in_ready;
  assign exp_w     = {1'b0, cmp_a_q} + {1'b0, cmp_b_q} + (WIDTH+1)'(cmp_cin_q);
  assign mism      = cmp_vld_q && (exp_w != cmp_got_q);

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign vec_count = vec_q;
  assign err_count = err_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    vec_d    = vec_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d = num_vectors;
          vec_d    = '0;
          err_d    = '0;
          state_d  = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) vec_d = vec_q + CNT_W'(1);
        if (mism && (err_q != '1)) err_d = err_q + CNT_W'(1);
        // in_ready is low once the target is reached, so the last vector drains on this edge
        if (vec_q == target_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      vec_q     <= '0;
      err_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      cmp_cin_q <= 1'b0;
      cmp_got_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      cmp_vld_q <= accept;
      if (accept) begin
        cmp_a_q   <= a;
        cmp_b_q   <= b;
        cmp_cin_q <= cin;
        cmp_got_q <= {cout, sum};
      end
    end
  end

`ifdef ADDER_CHECKER_CAPTURE_EN
  logic [CNT_W-1:0] cmp_idx_q;
  logic [CNT_W-1:0] fidx_q;
  logic [WIDTH-1:0] fa_q, fb_q;
  logic             fcin_q;
  logic [WIDTH:0]   fgot_q, fexp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_idx_q <= '0;
    end else if (accept) begin
      cmp_idx_q <= vec_q;
    end
  end

  // err_q is still zero on the edge that records the first mismatch of a run
  always_ff @(posedge clk) begin
    if (rst || (start && (state_q != RUN))) begin
      fidx_q <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      fcin_q <= 1'b0;
      fgot_q <= '0;
      fexp_q <= '0;
    end else if (mism && (err_q == '0)) begin
      fidx_q <= cmp_idx_q;
      fa_q   <= cmp_a_q;
      fb_q   <= cmp_b_q;
      fcin_q <= cmp_cin_q;
      fgot_q <= cmp_got_q;
      fexp_q <= exp_w;
    end
  end

  assign fail_idx = fidx_q;
  assign fail_a   = fa_q;
  assign fail_b   = fb_q;
  assign fail_cin = fcin_q;
  assign fail_got = fgot_q;
  assign fail_exp = fexp_q;
`else
  assign fail_idx = '0;
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_cin = 1'b0;
  assign fail_got = '0;
  assign fail_exp = '0;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: scoreboard of expected err_count per accepted vector,
// plus scenario checks for run control, capture and reset.
module tb_adder_checker;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0, b = '0, sum = '0;
  logic             cin = 1'b0, cout = 1'b0;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_count, err_count, fail_idx;
  logic [WIDTH-1:0] fail_a, fail_b;
  logic             fail_cin;
  logic [WIDTH:0]   fail_got, fail_exp;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_err  = 0;
  int sb[$];

  adder_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .fail_idx(fail_idx),
    .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
    .fail_got(fail_got), .fail_exp(fail_exp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input int n);
    num_vectors = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    mdl_err = 0;
    sb.delete();
  endtask

  // Drives one vector for one edge and records the expected error count after it is compared.
  task automatic send_vec(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [8:0] got);
    logic [8:0] gold;
    gold = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
    if (gold != got) mdl_err++;
    sb.push_back(mdl_err);
    a = va; b = vb; cin = vc; {cout, sum} = got;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy, done, pass, in_ready} !== 4'b0 || vec_count !== '0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy=%b done=%b pass=%b rdy=%b vec=%0d err=%0d exp all 0",
               busy, done, pass, in_ready, vec_count, err_count);
    end
    n_checks++;
    if ({fail_idx, fail_a, fail_b, fail_cin, fail_got, fail_exp} !== '0) begin
      n_fail++;
      $display("FAIL reset_fail got idx=%0h got=%0h exp_reg=%0h exp 0", fail_idx, fail_got, fail_exp);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass_run();
    logic [7:0] ta [4] = '{8'hFF, 8'h10, 8'h80, 8'h00};
    logic [7:0] tb [4] = '{8'h01, 8'h20, 8'h80, 8'h00};
    logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] tg [4] = '{9'h100, 9'h030, 9'h101, 9'h001};
    int e;
    start_run(4);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pass_busy got busy=%b rdy=%b exp 1/1", busy, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      send_vec(ta[i], tb[i], tc[i], tg[i]);
      n_checks++;
      if (vec_count !== CNT_W'(i + 1)) begin
        n_fail++; $display("FAIL pass_vec%0d got %0d exp %0d", i, vec_count, i + 1);
      end
      if (i > 0) begin
        e = sb.pop_front(); n_checks++;
        if (err_count !== CNT_W'(e)) begin
          n_fail++; $display("FAIL pass_err%0d got %0d exp %0d", i - 1, err_count, e);
        end
      end
    end
    tick();
    e = sb.pop_front(); n_checks++;
    if (err_count !== CNT_W'(e) || done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_end got err=%0d done=%b pass=%b busy=%b exp %0d/1/1/0",
               err_count, done, pass, busy, e);
    end
  endtask

  task automatic test_single_mismatch();
    logic [7:0] ta [3] = '{8'h01, 8'h12, 8'hAA};
    logic [7:0] tb [3] = '{8'h02, 8'h34, 8'h55};
    logic       tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] tg [3] = '{9'h003, 9'h046, 9'h100};
    int e;
    start_run(3);
    for (int i = 0; i < 3; i++) begin
      send_vec(ta[i], tb[i], tc[i], tg[i]);
      if (i > 0) begin
        e = sb.pop_front(); n_checks++;
        if (err_count !== CNT_W'(e)) begin
          n_fail++; $display("FAIL one_err%0d got %0d exp %0d", i - 1, err_count, e);
        end
      end
    end
    tick();
    e = sb.pop_front(); n_checks++;
    if (err_count !== CNT_W'(e) || done !== 1'b1 || pass !== 1'b0 || vec_count !== 16'd3) begin
      n_fail++;
      $display("FAIL one_end got err=%0d done=%b pass=%b vec=%0d exp %0d/1/0/3",
               err_count, done, pass, vec_count, e);
    end
    n_checks++;
`ifdef ADDER_CHECKER_CAPTURE_EN
    if (fail_idx !== 16'd1 || fail_exp !== 9'h047 || fail_got !== 9'h046 ||
        fail_a !== 8'h12 || fail_b !== 8'h34 || fail_cin !== 1'b1) begin
      n_fail++;
      $display("FAIL one_capture got idx=%0d a=%h b=%h cin=%b got=%h exp=%h exp 1/12/34/1/046/047",
               fail_idx, fail_a, fail_b, fail_cin, fail_got, fail_exp);
    end
`else
    if ({fail_idx, fail_a, fail_b, fail_cin, fail_got, fail_exp} !== '0) begin
      n_fail++; $display("FAIL one_capture_off got idx=%0d got=%h exp=%h exp 0", fail_idx, fail_got, fail_exp);
    end
`endif
  endtask

  task automatic test_double_mismatch();
    logic [7:0] ta [3] = '{8'h7F, 8'h03, 8'hC0};
    logic [7:0] tb [3] = '{8'h01, 8'h04, 8'h40};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] tg [3] = '{9'h000, 9'h007, 9'h100};
    int e;
    start_run(3);
    for (int i = 0; i < 3; i++) begin
      send_vec(ta[i], tb[i], tc[i], tg[i]);
      if (i > 0) begin
        e = sb.pop_front(); n_checks++;
        if (err_count !== CNT_W'(e)) begin
          n_fail++; $display("FAIL two_err%0d got %0d exp %0d", i - 1, err_count, e);
        end
      end
    end
    tick();
    e = sb.pop_front(); n_checks++;
    if (err_count !== 16'd2 || e != 2 || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL two_end got err=%0d model=%0d pass=%b done=%b exp 2/2/0/1", err_count, e, pass, done);
    end
    n_checks++;
`ifdef ADDER_CHECKER_CAPTURE_EN
    if (fail_idx !== 16'd0 || fail_a !== 8'h7F || fail_b !== 8'h01 || fail_cin !== 1'b0 ||
        fail_got !== 9'h000 || fail_exp !== 9'h080) begin
      n_fail++;
      $display("FAIL two_capture got idx=%0d a=%h b=%h got=%h exp=%h exp 0/7f/01/000/080",
               fail_idx, fail_a, fail_b, fail_got, fail_exp);
    end
`else
    if ({fail_idx, fail_a, fail_b, fail_cin, fail_got, fail_exp} !== '0) begin
      n_fail++; $display("FAIL two_capture_off got idx=%0d got=%h exp=%h exp 0", fail_idx, fail_got, fail_exp);
    end
`endif
  endtask

  task automatic test_zero_vectors();
    start_run(0);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || vec_count !== '0 ||
        err_count !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_run got done=%b pass=%b busy=%b vec=%0d err=%0d rdy=%b exp 1/1/0/0/0/0",
               done, pass, busy, vec_count, err_count, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    start_run(2);
    a = 8'h05; b = 8'h06; cin = 1'b0; {cout, sum} = 9'h00B;
    in_valid = 1'b1;
    num_vectors = 16'd7;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) begin
        n_checks++;
        if (in_ready !== 1'b0 || vec_count !== 16'd2) begin
          n_fail++; $display("FAIL b2b_ready got rdy=%b vec=%0d exp 0/2", in_ready, vec_count);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (vec_count !== 16'd2 || err_count !== '0 || done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end got vec=%0d err=%0d done=%b pass=%b busy=%b exp 2/0/1/1/0",
               vec_count, err_count, done, pass, busy);
    end
  endtask

  task automatic test_reset_midrun();
    start_run(5);
    send_vec(8'h11, 8'h22, 1'b0, 9'h033);
    send_vec(8'h01, 8'h01, 1'b0, 9'h005);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, done, pass, in_ready} !== 4'b0 || vec_count !== '0 || err_count !== '0 ||
        {fail_idx, fail_got, fail_exp} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst got busy=%b done=%b pass=%b rdy=%b vec=%0d err=%0d fidx=%0d exp all 0",
               busy, done, pass, in_ready, vec_count, err_count, fail_idx);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (err_count !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_flush got err=%0d busy=%b exp 0/0", err_count, busy);
    end
    start_run(2);
    send_vec(8'hFE, 8'h01, 1'b1, 9'h100);
    send_vec(8'h40, 8'h40, 1'b0, 9'h080);
    tick();
    n_checks++;
    if (vec_count !== 16'd2 || err_count !== '0 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rerun got vec=%0d err=%0d done=%b pass=%b exp 2/0/1/1",
               vec_count, err_count, done, pass);
    end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_single_mismatch();
    test_double_mismatch();
    test_zero_vectors();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_checker.md
# adder_checker

- Synthesizable response checker for the team's WIDTH-bit adders (carry-select, ripple, future variants): it sits on the adder output side and consumes {a, b, cin, sum, cout} vectors over a valid/ready handshake.
- For each vector it computes the golden a+b+cin and compares it against the DUT result.
- It counts accepted vectors and mismatches, and latches the first failing vector.
- It runs a bounded test of num_vectors vectors per start command and reports done/pass, so adders can be self-checked on silicon/FPGA as well as in simulation.

## Interface
- WIDTH, 8, operand/sum width
- CNT_W, 16, width of vector and error counters
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a test run
- num_vectors  input  CNT_W  vectors to check; sampled on start
- in_valid  input  1  vector present on a/b/cin/sum/cout
- in_ready  output  1  checker accepts vector this cycle
- a, b  input  WIDTH  operands applied to DUT
- cin  input  1  carry-in applied to DUT
- sum  input  WIDTH  DUT sum
- cout  input  1  DUT carry-out
- busy  output  1  run in progress
- done  output  1  run complete (level, held until next start/rst)
- pass  output  1  valid when done: err_count==0
- vec_count  output  CNT_W  vectors accepted this run
- err_count  output  CNT_W  mismatches this run, saturating
- fail_idx  output  CNT_W  vec_count value (0-based) of first mismatch
- fail_a, fail_b  output  WIDTH  operands of first mismatch
- fail_cin  output  1  carry-in of first mismatch
- fail_got  output  WIDTH+1  DUT {cout,sum} of first mismatch
- fail_exp  output  WIDTH+1  golden {cout,sum} of first mismatch

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE. All outputs reset to 0.
- IDLE/DONE + start: clear vec_count, err_count, and all fail_* registers; latch num_vectors. Next state is RUN, or DONE if num_vectors==0 (pass=1).
- start while in RUN is ignored.
- RUN: in_ready = (vec_count != target). A vector is accepted on a cycle where in_valid && in_ready.
- Accepted vector: registered into a one-deep compare stage; vec_count increments on the same edge.
- Compare stage: exp = {1'b0,a}+{1'b0,b}+cin, computed at WIDTH+1 bits, so carry-out is bit WIDTH. Mismatch iff exp != {cout,sum}.
- On mismatch: err_count increments, saturating at all-ones. If this is the first mismatch of the run, capture fail_* (fail_idx = index of that vector).
- RUN -> DONE when vec_count==target and the compare stage is empty.
- In DONE: done=1, busy=0, pass=(err_count==0). Counters and fail_* hold.
- busy=1 exactly in RUN. in_ready=0 outside RUN.
- in_valid in IDLE/DONE is ignored (not counted).

## Timing
- Accept at edge N: vec_count updates at N; err_count/fail_* update at N+1.
- Back-to-back accepts sustain 1 vector/cycle.
- Last accept at edge N -> done=1 after edge N+1.
- start at edge S -> busy=1 after S. For num_vectors==0, done=1 after S.
- rst mid-run: IDLE on next edge, compare stage flushed, all outputs 0.
- rst has priority over start.

## Configuration
- ADDER_CHECKER_CAPTURE_EN defined: fail_* registers implemented as described.
- ADDER_CHECKER_CAPTURE_EN undefined: fail_* outputs tied to 0 and no capture logic is built. Counting, done, and pass behave identically.

## Test plan
- rst, then start with num_vectors=4; feed 4 correct vectors including a=0xFF,b=0x01,cin=0 -> {cout,sum}=0x100. Expect vec_count=4, err_count=0, done=1, pass=1 one cycle after the last accept.
- num_vectors=3; vector index 1 has a=0x12,b=0x34,cin=1,sum=0x46 (expected 0x47). Expect err_count=1, pass=0, fail_idx=1, fail_exp=0x047, fail_got=0x046.
- Two mismatches at indices 0 and 2. Expect err_count=2 with fail_* still describing index 0. Repeat with the macro undefined: fail_*=0, err_count=2.
- num_vectors=2 with in_valid held high for 5 cycles. Expect in_ready low after 2 accepts, vec_count=2, and extra vectors not counted. Also: start pulsed during RUN is ignored.
- start with num_vectors=0 -> done=1, pass=1, vec_count=0 after one edge.
- Assert rst after 2 of 5 vectors -> all outputs 0 next cycle; a new start runs cleanly from zero.
